// File: rtl/irq_exc_ctrl_pkg.sv
// Shared encodings for the interrupt/exception sequencer and the Control decoder.
// Control uses the PCSrc and RegDst/MemToReg codes to steer the trap entry path.
package irq_exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_KERN = 2'd2
    } irq_state_e;

    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;
    localparam logic [1:0] XP_SEL    = 3'b11;

endpackage

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception sequencer: picks a safe ID slot for trap entry, holds EPC,
// and masks interrupts while the handler runs.
module irq_exc_ctrl
    import irq_exc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_req,
    input  logic              ex_illegal,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              branch_flush,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] pc_id,
    output logic              take_irq,
    output logic              take_exc,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc,
    output logic              kernel,
    output logic              pending,
    output logic [CNT_W-1:0]  irq_count
);

    irq_state_e        state_r;
    irq_state_e        state_nxt_s;
    logic              pending_r;
    logic [ADDR_W-1:0] epc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              slot_ok_s;
    logic              take_irq_s;
    logic              take_exc_s;
    logic              ret_s;

    // Slot qualification and trap decisions; an exception always wins the slot.
    always_comb begin
        slot_ok_s  = id_valid & ~stall & ~branch_flush;
        take_exc_s = ex_illegal & slot_ok_s;
        take_irq_s = (state_r == ST_PEND) & slot_ok_s & ~ex_illegal;
        ret_s      = ret_valid & slot_ok_s;
    end

    // Next-state logic; a request arriving with the return re-enters PEND directly.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_exc_s) begin
                    state_nxt_s = ST_KERN;
                end else if (irq_req) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (take_exc_s || take_irq_s) begin
                    state_nxt_s = ST_KERN;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            ST_KERN: begin
                if (take_exc_s) begin
                    state_nxt_s = ST_KERN;
                end else if (ret_s) begin
                    state_nxt_s = (pending_r | irq_req) ? ST_PEND : ST_IDLE;
                end else begin
                    state_nxt_s = ST_KERN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pending flag, return address and taken-interrupt counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            epc_r     <= {ADDR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (take_irq_s) begin
                pending_r <= 1'b0;
            end else if (irq_req) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            // Exceptions skip the faulting instruction; interrupts re-execute it.
            if (take_exc_s) begin
                epc_r <= pc_id + ADDR_W'(32'd4);
            end else if (take_irq_s) begin
                epc_r <= pc_id;
            end else begin
                epc_r <= epc_r;
            end
            if (take_irq_s) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign take_irq  = take_irq_s;
    assign take_exc  = take_exc_s;
    assign irq_ack   = take_irq_s;
    assign epc       = epc_r;
    assign kernel    = (state_r == ST_KERN);
    assign pending   = pending_r;
    assign irq_count = cnt_r;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Self-checking bench for irq_exc_ctrl: mode/pending reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_irq_exc_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              irq_req;
    logic              ex_illegal;
    logic              id_valid;
    logic              stall;
    logic              branch_flush;
    logic              ret_valid;
    logic [ADDR_W-1:0] pc_id;
    logic              take_irq;
    logic              take_exc;
    logic              irq_ack;
    logic [ADDR_W-1:0] epc;
    logic              kernel;
    logic              pending;
    logic [CNT_W-1:0]  irq_count;

    int n_cmp  = 0;
    int n_fail = 0;

    irq_exc_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .irq_req(irq_req), .ex_illegal(ex_illegal),
        .id_valid(id_valid), .stall(stall), .branch_flush(branch_flush),
        .ret_valid(ret_valid), .pc_id(pc_id), .take_irq(take_irq),
        .take_exc(take_exc), .irq_ack(irq_ack), .epc(epc), .kernel(kernel),
        .pending(pending), .irq_count(irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: handler mode bit, latched request, return address, count.
    bit          m_kern;
    bit          m_pend;
    logic [31:0] m_epc;
    int          m_cnt;
    bit          started = 1'b0;

    function automatic bit slot_now();
        return id_valid && !stall && !branch_flush;
    endfunction

    function automatic bit exp_exc();
        return ex_illegal && slot_now();
    endfunction

    function automatic bit exp_irq();
        return m_pend && !m_kern && slot_now() && !ex_illegal;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (!reset) begin
            m_kern = 1'b0;
            m_pend = 1'b0;
            m_epc  = 32'd0;
            m_cnt  = 0;
        end else begin
            bit e;
            bit i;
            e = exp_exc();
            i = exp_irq();
            if (e) begin
                m_epc  = pc_id + 32'd4;
                m_kern = 1'b1;
            end else if (i) begin
                m_epc  = pc_id;
                m_kern = 1'b1;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end else if (m_kern && ret_valid && slot_now()) begin
                m_kern = 1'b0;
            end
            if (i) m_pend = 1'b0;
            else if (irq_req) m_pend = 1'b1;
        end
    end

    // Compare process, sampling away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("m_epc", epc, m_epc);
            check("m_kernel", {31'd0, kernel}, {31'd0, m_kern});
            check("m_pending", {31'd0, pending}, {31'd0, m_pend});
            check("m_count", {28'd0, irq_count}, m_cnt);
            if (reset) begin
                check("m_take_exc", {31'd0, take_exc}, {31'd0, exp_exc()});
                check("m_take_irq", {31'd0, take_irq}, {31'd0, exp_irq()});
                check("m_irq_ack", {31'd0, irq_ack}, {31'd0, exp_irq()});
            end
        end
    end

    task automatic drv(input bit irq, input bit ex, input bit v, input bit st,
                       input bit bf, input bit ret, input logic [31:0] pc);
        irq_req = irq; ex_illegal = ex; id_valid = v; stall = st;
        branch_flush = bf; ret_valid = ret; pc_id = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
        tick();
        tick();
        check("reset_epc", epc, 32'h0);
        check("reset_kernel", {31'd0, kernel}, 32'd0);
        check("reset_pending", {31'd0, pending}, 32'd0);
        check("reset_count", {28'd0, irq_count}, 32'd0);
        reset = 1'b1;

        // Basic interrupt
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3c);
        check("basic_no_early_take", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
        check("basic_take", {31'd0, take_irq}, 32'd1);
        check("basic_ack", {31'd0, irq_ack}, 32'd1);
        tick();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44);
        check("basic_epc", epc, 32'h40);
        check("basic_kernel", {31'd0, kernel}, 32'd1);
        check("basic_count", {28'd0, irq_count}, 32'd1);

        // Masking in the handler, then return to a pending request
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h50);
        check("mask_no_take", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h54);
        check("mask_pending", {31'd0, pending}, 32'd1);
        check("mask_no_take2", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h70);
        check("ret_kernel_off", {31'd0, kernel}, 32'd0);
        check("ret_take", {31'd0, take_irq}, 32'd1);
        tick();
        check("ret_epc", epc, 32'h70);
        check("ret_count", {28'd0, irq_count}, 32'd2);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h74);
        tick();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h78);
        check("idle_kernel", {31'd0, kernel}, 32'd0);

        // Deferral by stall and branch flush
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h84);
        check("defer_stall1", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h84);
        check("defer_stall2", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h88);
        check("defer_flush", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
        check("defer_take", {31'd0, take_irq}, 32'd1);
        tick();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204);
        check("defer_epc", epc, 32'h200);
        check("defer_count", {28'd0, irq_count}, 32'd3);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h208);
        tick();

        // Exception wins the slot over a pending interrupt
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h90);
        tick();
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        check("prio_exc", {31'd0, take_exc}, 32'd1);
        check("prio_no_irq", {31'd0, take_irq}, 32'd0);
        tick();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
        check("prio_epc", epc, 32'h104);
        check("prio_pending", {31'd0, pending}, 32'd1);

        // Nested fault, stalled illegal instruction, epc wrap
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000010);
        check("nest_exc", {31'd0, take_exc}, 32'd1);
        tick();
        check("nest_epc", epc, 32'h80000014);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        check("held_exc_stalled", {31'd0, take_exc}, 32'd0);
        tick();
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300);
        check("held_exc_taken", {31'd0, take_exc}, 32'd1);
        tick();
        check("held_epc", epc, 32'h304);
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC);
        tick();
        check("wrap_epc", epc, 32'h0);

        // Return with the request still pending, then counter wrap
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3f0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400);
        check("pend_ret_take", {31'd0, take_irq}, 32'd1);
        tick();
        for (int k = 0; k < 12; k++) begin
            drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500 + 32'(k * 8));
            tick();
            drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h504 + 32'(k * 8));
            tick();
        end
        check("count_wrap", {28'd0, irq_count}, 32'd0);
        check("count_wrap_epc", epc, 32'h55c);

        // Reset in the same cycle as a take
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h604);
        tick();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h608);
        check("rst_pre_take", {31'd0, take_irq}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60c);
        check("rst_kernel", {31'd0, kernel}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_count", {28'd0, irq_count}, 32'd0);

        // Mixed traffic checked by the model alone
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) != 0);
            drv(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 4) == 0),
                $urandom() & 32'hFFFFFFFC);
            tick();
        end
        reset = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
